// File: rtl/iloveyou_flow_arbiter.sv
// ---------------------------------------------------------------------------
// iloveyou_flow_arbiter
//
// Purpose:
//    Shares one phrase-checking path between two byte streams (cap and low).
//    A round-robin arbiter grants one byte per cycle. Once a granted stream
//    starts the phrase "ILOVEYOU" (case-insensitive), the grant locks to that
//    stream until the phrase completes, breaks or times out. Accepted bytes
//    are forwarded downstream with their source. A completed phrase is
//    flagged with the owning source.
//
// Ports:
//    clk        - system clock, all logic on rising edge
//    rst        - synchronous reset, active-high
//    cap_valid  - cap stream byte present
//    cap_data   - cap stream byte (ASCII)
//    cap_ready  - cap byte accepted when high together with cap_valid
//    low_valid  - low stream byte present
//    low_data   - low stream byte (ASCII)
//    low_ready  - low byte accepted when high together with low_valid
//    out_valid  - forwarded byte valid, one pulse per accepted byte
//    out_data   - forwarded byte, raw (not case-folded)
//    out_src    - source of out_data: 0=cap, 1=low
//    hit        - one-cycle pulse when a full phrase arrives from one source
//    hit_src    - source of the phrase, valid when hit=1
//    busy       - high while the grant is locked to one source
// ---------------------------------------------------------------------------
module iloveyou_flow_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cap_valid,
   input  logic [7:0] cap_data,
   output logic       cap_ready,
   input  logic       low_valid,
   input  logic [7:0] low_data,
   output logic       low_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_src,
   output logic       hit,
   output logic       hit_src,
   output logic       busy
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [7:0]      CHAR_I  = 8'h49;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic [2:0]      idx_q, idx_d;
   logic            rrPtr_q, rrPtr_d;
   logic [TO_W-1:0] toCnt_q, toCnt_d;

   logic            outValid_q;
   logic [7:0]      outData_q;
   logic            outSrc_q;
   logic            hit_q, hit_d;
   logic            hitSrc_q, hitSrc_d;
   logic            busy_q;

   logic            capReady, lowReady;
   logic            capXfer, lowXfer, xfer, xferSrc;
   logic [7:0]      xferByte, folded, patByte;

   // Expected upper-case phrase character for the current match position.
   function automatic logic [7:0] patAt(input logic [2:0] i);
      case (i)
         3'd0:    patAt = 8'h49;
         3'd1:    patAt = 8'h4C;
         3'd2:    patAt = 8'h4F;
         3'd3:    patAt = 8'h56;
         3'd4:    patAt = 8'h45;
         3'd5:    patAt = 8'h59;
         3'd6:    patAt = 8'h4F;
         default: patAt = 8'h55;
      endcase
   endfunction

   // Grant selection. While idle, a lone valid source wins and a tie is broken
   // by the round-robin pointer. While locked, only the owner is offered ready
   // so the other stream holds its byte. Nothing is granted during reset.
   always_comb begin
      capReady = 1'b0;
      lowReady = 1'b0;
      if (!rst) begin
         if (state_q == LOCK) begin
            capReady = ~owner_q;
            lowReady = owner_q;
         end else if (cap_valid && (!low_valid || !rrPtr_q)) begin
            capReady = 1'b1;
         end else if (low_valid) begin
            lowReady = 1'b1;
         end
      end
   end

   // The accepted byte, its source, and its case-folded form. The grant logic
   // never raises both readys, so at most one transfer happens per cycle.
   always_comb begin
      capXfer  = cap_valid & capReady;
      lowXfer  = low_valid & lowReady;
      xfer     = capXfer | lowXfer;
      xferSrc  = lowXfer;
      xferByte = lowXfer ? low_data : cap_data;
      folded   = xferByte;
      if (xferByte >= 8'h61 && xferByte <= 8'h7A) begin
         folded = xferByte - 8'h20;
      end
      patByte  = patAt(idx_q);
   end

   // Next-state logic for the grant lock and phrase tracker. A mismatch that is
   // itself an "I" restarts the phrase instead of releasing the lock. Idle
   // cycles of the owner count toward a forced release.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      idx_d    = idx_q;
      rrPtr_d  = rrPtr_q;
      toCnt_d  = toCnt_q;
      hit_d    = 1'b0;
      hitSrc_d = hitSrc_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (folded == CHAR_I) begin
                  state_d = LOCK;
                  owner_d = xferSrc;
                  idx_d   = 3'd1;
                  toCnt_d = '0;
               end else begin
                  rrPtr_d = ~xferSrc;
               end
            end
         end
         LOCK: begin
            if (xfer) begin
               if (folded == patByte) begin
                  if (idx_q == 3'd7) begin
                     hit_d    = 1'b1;
                     hitSrc_d = owner_q;
                     state_d  = IDLE;
                     rrPtr_d  = ~owner_q;
                  end else begin
                     idx_d   = idx_q + 3'd1;
                     toCnt_d = '0;
                  end
               end else if (folded == CHAR_I) begin
                  idx_d   = 3'd1;
                  toCnt_d = '0;
               end else begin
                  state_d = IDLE;
                  rrPtr_d = ~owner_q;
               end
            end else if (toCnt_q == TO_LAST) begin
               state_d = IDLE;
               rrPtr_d = ~owner_q;
            end else begin
               toCnt_d = toCnt_q + TO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers plus registered outputs. Reset discards any partial
   // phrase, even in the middle of a lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         idx_q      <= 3'd0;
         rrPtr_q    <= 1'b0;
         toCnt_q    <= '0;
         outValid_q <= 1'b0;
         outData_q  <= 8'h00;
         outSrc_q   <= 1'b0;
         hit_q      <= 1'b0;
         hitSrc_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         idx_q      <= idx_d;
         rrPtr_q    <= rrPtr_d;
         toCnt_q    <= toCnt_d;
         outValid_q <= xfer;
         if (xfer) begin
            outData_q <= xferByte;
            outSrc_q  <= xferSrc;
         end
         hit_q      <= hit_d;
         hitSrc_q   <= hitSrc_d;
         busy_q     <= (state_d == LOCK);
      end
   end

   assign cap_ready = capReady;
   assign low_ready = lowReady;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_src   = outSrc_q;
   assign hit       = hit_q;
   assign hit_src   = hitSrc_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_iloveyou_flow_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iloveyou_flow_arbiter
//
// Purpose:
//    Self-checking bench for iloveyou_flow_arbiter. A driver feeds both
//    streams from byte queues, predicts grants with a reference model, and
//    pushes the expected forwarded byte into a scoreboard. A monitor pops the
//    scoreboard on every out_valid and compares the outputs.
// ---------------------------------------------------------------------------
module tb_iloveyou_flow_arbiter;

   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       cap_valid, low_valid;
   logic [7:0] cap_data, low_data;
   logic       cap_ready, low_ready;
   logic       out_valid, out_src, hit, hit_src, busy;
   logic [7:0] out_data;

   iloveyou_flow_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .cap_valid (cap_valid),
      .cap_data  (cap_data),
      .cap_ready (cap_ready),
      .low_valid (low_valid),
      .low_data  (low_data),
      .low_ready (low_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .hit       (hit),
      .hit_src   (hit_src),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       src;
      logic       hit;
      logic       hitSrc;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] capQ[$];
   logic [7:0] lowQ[$];

   int    checks = 0;
   int    passes = 0;
   int    capGapPct = 0;
   int    lowGapPct = 0;
   bit    capHeld = 0;
   bit    lowHeld = 0;
   string phrase = "ILOVEYOU";
   string noise  = "ILOVEYUAXilovyux";

   // Reference model: whether a phrase is in progress, who owns it, how many
   // phrase characters have matched, who wins the next tie, and how many
   // consecutive cycles the owner has been silent.
   bit mLocked = 0;
   bit mOwner  = 0;
   int mMatched = 0;
   bit mPrefer = 0;
   int mIdle = 0;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] upper(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
   endfunction

   task automatic pushStr(input bit src, input string s);
      for (int i = 0; i < s.len(); i++) begin
         if (src) lowQ.push_back(s[i]);
         else     capQ.push_back(s[i]);
      end
   endtask

   task automatic pushPhrase(input bit src);
      logic [7:0] c;
      for (int i = 0; i < 8; i++) begin
         c = phrase[i];
         if ($urandom_range(1) == 1) c = c + 8'd32;
         if (src) lowQ.push_back(c);
         else     capQ.push_back(c);
      end
   endtask

   // Apply the phrase rules to one accepted byte and queue the expected
   // downstream response.
   task automatic modelAccept(input logic [7:0] b, input bit s);
      logic [7:0] f;
      bit         hitNow;
      bit         hs;
      f      = upper(b);
      hitNow = 0;
      hs     = 0;
      if (!mLocked) begin
         if (f == 8'h49) begin
            mLocked  = 1;
            mOwner   = s;
            mMatched = 1;
            mIdle    = 0;
         end else begin
            mPrefer = !s;
         end
      end else if (f == phrase[mMatched]) begin
         if (mMatched == 7) begin
            hitNow  = 1;
            hs      = mOwner;
            mLocked = 0;
            mPrefer = !mOwner;
         end else begin
            mMatched++;
            mIdle = 0;
         end
      end else if (f == 8'h49) begin
         mMatched = 1;
         mIdle    = 0;
      end else begin
         mLocked = 0;
         mPrefer = !mOwner;
      end
      expQ.push_back({b, s, hitNow, hs});
   endtask

   // One clock cycle of stimulus: drive inputs after the falling edge, check
   // busy and both readys against the model, then advance the model as the
   // next rising edge will.
   task automatic applyStimulus(input bit doReset);
      bit capV, lowV, expCapR, expLowR;
      @(negedge clk);
      checkOutput("busy", busy, mLocked);
      rst  = doReset;
      capV = capQ.size() > 0 && (capHeld || $urandom_range(99) >= capGapPct);
      lowV = lowQ.size() > 0 && (lowHeld || $urandom_range(99) >= lowGapPct);
      cap_valid = capV;
      low_valid = lowV;
      cap_data  = capV ? capQ[0] : 8'h00;
      low_data  = lowV ? lowQ[0] : 8'h00;
      #1;
      if (doReset) begin
         expCapR = 0;
         expLowR = 0;
      end else if (mLocked) begin
         expCapR = !mOwner;
         expLowR = mOwner;
      end else if (capV && lowV) begin
         expCapR = !mPrefer;
         expLowR = mPrefer;
      end else begin
         expCapR = capV;
         expLowR = lowV;
      end
      checkOutput("cap_ready", cap_ready, expCapR);
      checkOutput("low_ready", low_ready, expLowR);
      if (doReset) begin
         mLocked  = 0;
         mOwner   = 0;
         mMatched = 0;
         mPrefer  = 0;
         mIdle    = 0;
         capHeld  = capV;
         lowHeld  = lowV;
      end else if (capV && expCapR) begin
         capHeld = 0;
         lowHeld = lowV;
         modelAccept(capQ.pop_front(), 1'b0);
      end else if (lowV && expLowR) begin
         lowHeld = 0;
         capHeld = capV;
         modelAccept(lowQ.pop_front(), 1'b1);
      end else begin
         capHeld = capV;
         lowHeld = lowV;
         if (mLocked) begin
            mIdle++;
            if (mIdle == TIMEOUT) begin
               mLocked = 0;
               mPrefer = !mOwner;
            end
         end
      end
   endtask

   task automatic runUntilEmpty(input int maxCycles);
      int n = 0;
      while ((capQ.size() > 0 || lowQ.size() > 0) && n < maxCycles) begin
         applyStimulus(0);
         n++;
      end
      if (capQ.size() > 0 || lowQ.size() > 0) checkOutput("drain_timeout", 1, 0);
      repeat (3) applyStimulus(0);
   endtask

   // Monitor: every forwarded byte must match the oldest expectation; hit may
   // only appear together with a forwarded byte.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_out_valid", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("out_data", out_data, e.data);
               checkOutput("out_src", out_src, e.src);
               checkOutput("hit", hit, e.hit);
               if (e.hit) checkOutput("hit_src", hit_src, e.hitSrc);
            end
         end else begin
            checkOutput("hit_idle", hit, 0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      cap_valid = 1'b0;
      low_valid = 1'b0;
      cap_data  = 8'h00;
      low_data  = 8'h00;

      // Reset with both streams requesting, then round-robin on plain bytes.
      pushStr(0, "AAA");
      pushStr(1, "bbb");
      repeat (3) applyStimulus(1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_src", out_src, 0);
      checkOutput("rst_hit", hit, 0);
      checkOutput("rst_hit_src", hit_src, 0);
      checkOutput("rst_busy", busy, 0);
      runUntilEmpty(50);

      // Locked phrase from cap with low competing.
      pushStr(0, "ILOVEYOU");
      pushStr(1, "xxxxxxxxxx");
      runUntilEmpty(60);

      // Mixed case from low alone.
      pushStr(1, "iLoVeYoU");
      runUntilEmpty(40);

      // Break, then restart on a repeated "I".
      pushStr(0, "ILOX");
      pushStr(1, "zz");
      runUntilEmpty(40);
      pushStr(0, "IILOVEYOU");
      runUntilEmpty(40);

      // Timeout: cap goes silent mid-phrase while low waits.
      pushStr(0, "IL");
      pushStr(1, "xxxxxxxxxxxxxxxxxxxx");
      runUntilEmpty(80);
      pushStr(0, "OVEYOU");
      runUntilEmpty(40);

      // Randomized traffic with gaps and occasional mid-run reset.
      capGapPct = 25;
      lowGapPct = 25;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (capQ.size() < 4 && $urandom_range(3) == 0) begin
            if ($urandom_range(1) == 1) pushPhrase(0);
            else capQ.push_back(noise[$urandom_range(noise.len() - 1)]);
         end
         if (lowQ.size() < 4 && $urandom_range(3) == 0) begin
            if ($urandom_range(1) == 1) pushPhrase(1);
            else lowQ.push_back(noise[$urandom_range(noise.len() - 1)]);
         end
         applyStimulus($urandom_range(299) == 0);
      end
      capGapPct = 0;
      lowGapPct = 0;
      runUntilEmpty(500);

      checkOutput("scoreboard_empty", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
